// File: rtl/sd_video_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_video_pkg : SD-SDI 525-line constants, bar table and XYZ word helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package sd_video_pkg;

  localparam logic [9:0] TRS_ONE  = 10'h3FF;
  localparam logic [9:0] TRS_ZERO = 10'h000;
  localparam logic [9:0] BLANK_Y  = 10'h040;
  localparam logic [9:0] BLANK_C  = 10'h200;

  localparam logic [10:0] BLANK_START  = 11'd4;
  localparam logic [10:0] SAV_START    = 11'd272;
  localparam logic [10:0] ACTIVE_START = 11'd276;
  localparam logic [10:0] BAR_WIDTH    = 11'd180;

  // F is set outside lines 4..265, V on lines 1..19 and 264..282
  localparam logic [9:0] F0_LAST  = 10'd3;
  localparam logic [9:0] F1_FIRST = 10'd266;
  localparam logic [9:0] V0_LAST  = 10'd19;
  localparam logic [9:0] V1_FIRST = 10'd264;
  localparam logic [9:0] V1_LAST  = 10'd282;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } bar_t;

  localparam logic [2:0] BAR_BLACK = 3'd7;

  localparam bar_t BARS [8] = '{
    '{10'h2D0, 10'h200, 10'h200},
    '{10'h288, 10'h0B0, 10'h238},
    '{10'h20C, 10'h270, 10'h0B0},
    '{10'h1C0, 10'h120, 10'h0E8},
    '{10'h150, 10'h2E0, 10'h318},
    '{10'h104, 10'h190, 10'h350},
    '{10'h08C, 10'h350, 10'h1C8},
    '{10'h040, 10'h200, 10'h200}
  };

  function automatic logic [9:0] xyz(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_ce_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_ce_divider : divides clk_400_000 down to one word strobe per CE_DIV clocks
// Revision: 1.0
// ---------------------------------------------------------------------------
module sd_ce_divider #(
  parameter int CE_DIV = 15
) (
  input  logic clk_400_000,
  input  logic RESET,
  input  logic locked,
  output logic strobe
);

  localparam int DW = $clog2(CE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk_400_000 or posedge RESET) begin
    if (RESET) begin
      div <= '0;
    end else if (!locked) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign strobe = locked && (div == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/sd_colorbar_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_colorbar_gen : 525-line SD-SDI 4:2:2 word source (TRS, blanking, 75% bars)
// Revision: 1.0
// ---------------------------------------------------------------------------
module sd_colorbar_gen
  import sd_video_pkg::*;
#(
  parameter int CE_DIV          = 15,
  parameter int WORDS_PER_LINE  = 1716,
  parameter int LINES_PER_FRAME = 525
) (
  input  logic       clk_400_000,
  input  logic       RESET,
  input  logic       locked,
  input  logic       pattern_en,
  output logic [9:0] data_out,
  output logic [2:0] ce_out,
  output logic [9:0] line_num,
  output logic       field,
  output logic       in_active,
  output logic       frame_start
);

  localparam logic [10:0] WLAST = 11'(WORDS_PER_LINE - 1);
  localparam logic [9:0]  LLAST = 10'(LINES_PER_FRAME);

  logic        strobe;
  // wcnt/line_cnt address the word that the next strobe will load
  logic [10:0] wcnt;
  logic [9:0]  line_cnt;

  logic        f_bit;
  logic        v_bit;
  logic        active;
  logic [10:0] a;
  logic [2:0]  bar;
  bar_t        bv;
  logic [9:0]  word;

  sd_ce_divider #(
    .CE_DIV(CE_DIV)
  ) u_div (
    .clk_400_000(clk_400_000),
    .RESET      (RESET),
    .locked     (locked),
    .strobe     (strobe)
  );

  always_comb begin
    f_bit  = (line_cnt <= F0_LAST) || (line_cnt >= F1_FIRST);
    v_bit  = (line_cnt <= V0_LAST) || ((line_cnt >= V1_FIRST) && (line_cnt <= V1_LAST));
    active = !v_bit && (wcnt >= ACTIVE_START);
    a      = wcnt - ACTIVE_START;
    bar    = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (a >= BAR_WIDTH * 11'(i)) bar = 3'(i);
    end
    bv   = pattern_en ? BARS[bar] : BARS[BAR_BLACK];
    word = wcnt[0] ? BLANK_Y : BLANK_C;
    if (wcnt < BLANK_START || (wcnt >= SAV_START && wcnt < ACTIVE_START)) begin
      case (wcnt[1:0])
        2'd0:    word = TRS_ONE;
        2'd3:    word = xyz(f_bit, v_bit, wcnt < BLANK_START);
        default: word = TRS_ZERO;
      endcase
    end else if (active) begin
      case (a[1:0])
        2'd0:    word = bv.cb;
        2'd2:    word = bv.cr;
        default: word = bv.y;
      endcase
    end
  end

  always_ff @(posedge clk_400_000 or posedge RESET) begin
    if (RESET) begin
      data_out    <= BLANK_Y;
      ce_out      <= 3'b000;
      line_num    <= 10'd1;
      field       <= 1'b1;
      in_active   <= 1'b0;
      frame_start <= 1'b0;
      wcnt        <= '0;
      line_cnt    <= 10'd1;
    end else if (!locked) begin
      data_out    <= BLANK_Y;
      ce_out      <= 3'b000;
      line_num    <= 10'd1;
      field       <= 1'b1;
      in_active   <= 1'b0;
      frame_start <= 1'b0;
      wcnt        <= '0;
      line_cnt    <= 10'd1;
    end else if (strobe) begin
      data_out    <= word;
      ce_out      <= 3'b111;
      line_num    <= line_cnt;
      field       <= f_bit;
      in_active   <= active;
      frame_start <= (line_cnt == 10'd1) && (wcnt == 11'd0);
      if (wcnt == WLAST) begin
        wcnt     <= '0;
        line_cnt <= (line_cnt == LLAST) ? 10'd1 : line_cnt + 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end else begin
      ce_out      <= 3'b000;
      frame_start <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_colorbar_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sd_colorbar_gen : self-checking bench for sd_colorbar_gen
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sd_colorbar_gen;

  typedef struct {
    int         dut;
    int         line;
    int         wcnt;
    bit         pat;
    logic [9:0] data;
    bit         act;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  vec_t tbl[$];
  vec_t q_a[$];
  vec_t q_b[$];
  vec_t q_c[$];

  // A: full line, CE_DIV=4; B: full line, CE_DIV=2; C: 8-word lines for frame wrap
  logic rst_a, locked_a, pat_a;
  logic rst_b, locked_b, pat_b;
  logic rst_c, locked_c, pat_c;
  logic [9:0] a_data, b_data, c_data, a_line, b_line, c_line;
  logic [2:0] a_ce, b_ce, c_ce;
  logic a_field, b_field, c_field, a_act, b_act, c_act, a_fs, b_fs, c_fs;

  sd_colorbar_gen #(.CE_DIV(4), .WORDS_PER_LINE(1716), .LINES_PER_FRAME(525)) dut_a (
    .clk_400_000(clk), .RESET(rst_a), .locked(locked_a), .pattern_en(pat_a),
    .data_out(a_data), .ce_out(a_ce), .line_num(a_line), .field(a_field),
    .in_active(a_act), .frame_start(a_fs));

  sd_colorbar_gen #(.CE_DIV(2), .WORDS_PER_LINE(1716), .LINES_PER_FRAME(525)) dut_b (
    .clk_400_000(clk), .RESET(rst_b), .locked(locked_b), .pattern_en(pat_b),
    .data_out(b_data), .ce_out(b_ce), .line_num(b_line), .field(b_field),
    .in_active(b_act), .frame_start(b_fs));

  sd_colorbar_gen #(.CE_DIV(2), .WORDS_PER_LINE(8), .LINES_PER_FRAME(525)) dut_c (
    .clk_400_000(clk), .RESET(rst_c), .locked(locked_c), .pattern_en(pat_c),
    .data_out(c_data), .ce_out(c_ce), .line_num(c_line), .field(c_field),
    .in_active(c_act), .frame_start(c_fs));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic void add(input int d, input int l, input int w, input bit p,
                              input logic [9:0] v, input bit act);
    vec_t e;
    e.dut = d; e.line = l; e.wcnt = w; e.pat = p; e.data = v; e.act = act;
    tbl.push_back(e);
  endfunction

  task automatic check_a_reset(input string nm);
    check({nm, "_data"}, a_data, 10'h040);
    check({nm, "_ce"}, a_ce, 3'b000);
    check({nm, "_line"}, a_line, 10'd1);
    check({nm, "_field"}, a_field, 1'b1);
    check({nm, "_act"}, a_act, 1'b0);
    check({nm, "_fs"}, a_fs, 1'b0);
  endtask

  // Expects the first strobe CE_DIV (=4) clocks after the enabling negedge
  task automatic a_first_word(input string nm);
    int early = 0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (a_ce !== 3'b000) early++;
    end
    check({nm, "_early_ce"}, early, 0);
    @(negedge clk);
    check({nm, "_ce"}, a_ce, 3'b111);
    check({nm, "_data"}, a_data, 10'h3FF);
    check({nm, "_fs"}, a_fs, 1'b1);
    check({nm, "_line"}, a_line, 10'd1);
    @(negedge clk);
    check({nm, "_fs_pulse"}, a_fs, 1'b0);
  endtask

  initial begin
    // DUT A, line 1 (vertical blanking) and wrap into line 2
    add(0, 1, 1, 1, 10'h000, 0);   add(0, 1, 2, 1, 10'h000, 0);
    add(0, 1, 3, 1, 10'h3C4, 0);   add(0, 1, 4, 1, 10'h200, 0);
    add(0, 1, 5, 1, 10'h040, 0);   add(0, 1, 272, 1, 10'h3FF, 0);
    add(0, 1, 275, 1, 10'h3B0, 0); add(0, 1, 276, 1, 10'h200, 0);
    add(0, 1, 1715, 1, 10'h040, 0); add(0, 2, 0, 1, 10'h3FF, 0);
    // DUT B, line 20 bars then line 21 with pattern disabled
    add(1, 20, 3, 1, 10'h274, 0);    add(1, 20, 275, 1, 10'h200, 0);
    add(1, 20, 276, 1, 10'h200, 1);  add(1, 20, 277, 1, 10'h2D0, 1);
    add(1, 20, 456, 1, 10'h0B0, 1);  add(1, 20, 457, 1, 10'h288, 1);
    add(1, 20, 1534, 1, 10'h1C8, 1); add(1, 20, 1535, 1, 10'h08C, 1);
    add(1, 20, 1536, 1, 10'h200, 1); add(1, 20, 1537, 1, 10'h040, 1);
    add(1, 21, 276, 0, 10'h200, 1);  add(1, 21, 277, 0, 10'h040, 1);
    add(1, 21, 456, 0, 10'h200, 1);  add(1, 21, 457, 0, 10'h040, 1);
    add(1, 21, 1534, 0, 10'h200, 1);
    // DUT C, EAV XYZ across the F/V boundaries
    add(2, 1, 0, 1, 10'h3FF, 0);   add(2, 1, 3, 1, 10'h3C4, 0);
    add(2, 1, 4, 1, 10'h200, 0);   add(2, 1, 5, 1, 10'h040, 0);
    add(2, 3, 3, 1, 10'h3C4, 0);   add(2, 4, 3, 1, 10'h2D8, 0);
    add(2, 19, 3, 1, 10'h2D8, 0);  add(2, 20, 3, 1, 10'h274, 0);
    add(2, 263, 3, 1, 10'h274, 0); add(2, 264, 3, 1, 10'h2D8, 0);
    add(2, 265, 3, 1, 10'h2D8, 0); add(2, 266, 3, 1, 10'h3C4, 0);
    add(2, 282, 3, 1, 10'h3C4, 0); add(2, 283, 3, 1, 10'h368, 0);
    add(2, 525, 3, 1, 10'h368, 0); add(2, 525, 7, 1, 10'h040, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].dut)
        0:       q_a.push_back(tbl[i]);
        1:       q_b.push_back(tbl[i]);
        default: q_c.push_back(tbl[i]);
      endcase
    end

    rst_a = 1'b1; locked_a = 1'b0; pat_a = 1'b1;
    rst_b = 1'b1; locked_b = 1'b0; pat_b = q_b[0].pat;
    rst_c = 1'b1; locked_c = 1'b0; pat_c = 1'b1;

    fork
      begin : a_proc
        int err, cl, cw, found;
        logic [9:0] prev;
        vec_t v;
        repeat (3) @(negedge clk);
        check_a_reset("a_reset");
        rst_a = 1'b0;
        err = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (a_data !== 10'h040 || a_ce !== 3'b000) err++;
        end
        check("a_unlocked_hold", err, 0);
        locked_a = 1'b1;
        a_first_word("a_lock");

        // cadence over 10000 clocks plus scoreboard of line-1 words
        err = 0; cl = 1; cw = 1; prev = a_data;
        for (int k = 2; k < 10002; k++) begin
          @(negedge clk);
          if ((a_ce === 3'b111) != (k % 4 == 0)) err++;
          if (a_ce === 3'b000 && a_data !== prev) err++;
          prev = a_data;
          if (a_ce === 3'b111) begin
            if (q_a.size() > 0 && q_a[0].line == cl && q_a[0].wcnt == cw) begin
              v = q_a.pop_front();
              check($sformatf("a_L%0d_W%0d_data", cl, cw), a_data, v.data);
              check($sformatf("a_L%0d_W%0d_act", cl, cw), a_act, v.act);
              check($sformatf("a_L%0d_W%0d_line", cl, cw), a_line, cl);
            end
            if (cw == 1715) begin cw = 0; cl = cl + 1; end else cw = cw + 1;
          end
        end
        check("a_cadence", err, 0);
        check("a_pending", q_a.size(), 0);

        // asynchronous reset mid-line
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
          @(negedge clk);
          if (a_ce === 3'b111 && a_data === 10'h200 && a_line !== 10'd1) found = 1;
        end
        check("a_pre_reset_found", found, 1);
        #2 rst_a = 1'b1;
        #1 check_a_reset("a_async_reset");
        @(negedge clk);
        rst_a = 1'b0;
        a_first_word("a_rst_restart");

        // synchronous clear through locked
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
          @(negedge clk);
          if (a_ce === 3'b111 && a_data === 10'h200) found = 1;
        end
        check("a_pre_unlock_found", found, 1);
        locked_a = 1'b0;
        @(negedge clk);
        check("a_unlock_data", a_data, 10'h040);
        check("a_unlock_ce", a_ce, 3'b000);
        err = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (a_data !== 10'h040 || a_ce !== 3'b000) err++;
        end
        check("a_unlock_hold", err, 0);
        locked_a = 1'b1;
        a_first_word("a_relock");
      end

      begin : b_proc
        int cl, cw;
        vec_t v;
        repeat (2) @(negedge clk);
        rst_b = 1'b0; locked_b = 1'b1;
        cl = 1; cw = 0;
        for (int k = 0; k < 80000 && q_b.size() > 0; k++) begin
          @(negedge clk);
          if (b_ce === 3'b111) begin
            if (q_b[0].line == cl && q_b[0].wcnt == cw) begin
              v = q_b.pop_front();
              check($sformatf("b_L%0d_W%0d_P%0d_data", cl, cw, v.pat), b_data, v.data);
              check($sformatf("b_L%0d_W%0d_act", cl, cw), b_act, v.act);
              check($sformatf("b_L%0d_W%0d_line", cl, cw), b_line, cl);
              if (q_b.size() > 0) pat_b = q_b[0].pat;
            end
            if (cw == 1715) begin cw = 0; cl = cl + 1; end else cw = cw + 1;
          end
        end
        check("b_pending", q_b.size(), 0);
      end

      begin : c_proc
        int cl, cw, n, done, seq_err, last_line;
        bit exp_f;
        vec_t v;
        repeat (2) @(negedge clk);
        rst_c = 1'b0; locked_c = 1'b1;
        cl = 1; cw = 0; n = 0; done = 0; seq_err = 0; last_line = 0;
        for (int k = 0; k < 20000 && done == 0; k++) begin
          @(negedge clk);
          if (c_ce === 3'b111) begin
            if (n > 0 && c_fs === 1'b1) begin
              done = 1;
              check("c_wrap_line", c_line, 10'd1);
              check("c_last_line", last_line, 525);
            end else begin
              exp_f = (cl <= 3) || (cl >= 266);
              if (c_line !== 10'(cl) || c_field !== exp_f || c_act !== 1'b0 ||
                  c_fs !== ((cl == 1) && (cw == 0))) seq_err++;
              if (q_c.size() > 0 && q_c[0].line == cl && q_c[0].wcnt == cw) begin
                v = q_c.pop_front();
                check($sformatf("c_L%0d_W%0d_data", cl, cw), c_data, v.data);
              end
              last_line = c_line;
              if (cw == 7) begin
                cw = 0;
                cl = (cl == 525) ? 1 : cl + 1;
              end else cw = cw + 1;
              n++;
            end
          end
        end
        check("c_second_frame_start", done, 1);
        check("c_frame_strobes", n, 8 * 525);
        check("c_line_field_seq", seq_err, 0);
        check("c_pending", q_c.size(), 0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
